// File: rtl/decode_stage.sv
// decode_stage: RV32I decode of one instruction into a single registered control bundle.
// Latency: 1 cycle from accept to out_valid; sustains one instruction per cycle.
// Backpressure: in_ready drops while the held bundle is stalled, on a load-use hazard, on flush or in reset.
//
// Ports:
//   clk, rst                   clock (rising edge), asynchronous active-high reset
//   flush                      drop the held bundle and the incoming instruction (redirect)
//   in_valid/in_ready          fetch-side handshake; in_instr, in_pc carried with it
//   out_valid/out_ready        execute-side handshake for the registered bundle
//   out_pc, out_rs1/rs2/rd     PC and raw register indices of the held instruction
//   out_func3, out_func7       raw function fields
//   out_alu_op, out_imm_src    00 add/01 sub-cmp/10 func-decoded/11 pass B; 000 I/001 S/010 B/011 U/100 J
//   out_op1_src, out_op2_src   0 rs1 / 1 PC; 0 rs2 / 1 immediate
//   out_wb_src                 00 ALU, 01 memory, 10 PC+4
//   out_reg_write ... out_illegal  control flags
module decode_stage #(
  parameter int PC_WIDTH       = 32,
  parameter int ENABLE_M       = 0,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [31:0]               in_instr,
  input  logic [PC_WIDTH-1:0]       in_pc,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [PC_WIDTH-1:0]       out_pc,
  output logic [REG_ADDR_WIDTH-1:0] out_rs1,
  output logic [REG_ADDR_WIDTH-1:0] out_rs2,
  output logic [REG_ADDR_WIDTH-1:0] out_rd,
  output logic [2:0]                out_func3,
  output logic [6:0]                out_func7,
  output logic [1:0]                out_alu_op,
  output logic [2:0]                out_imm_src,
  output logic                      out_op1_src,
  output logic                      out_op2_src,
  output logic [1:0]                out_wb_src,
  output logic                      out_reg_write,
  output logic                      out_mem_write,
  output logic                      out_mem_read,
  output logic                      out_branch,
  output logic                      out_jump,
  output logic                      out_mul,
  output logic                      out_illegal
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic [1:0] alu_op;
    logic [2:0] imm_src;
    logic       op1_src;
    logic       op2_src;
    logic [1:0] wb_src;
    logic       reg_write;
    logic       mem_write;
    logic       mem_read;
    logic       branch;
    logic       jump;
    logic       mul;
    logic       illegal;
  } ctrl_t;

  typedef struct packed {
    logic [PC_WIDTH-1:0]       pc;
    logic [REG_ADDR_WIDTH-1:0] rs1;
    logic [REG_ADDR_WIDTH-1:0] rs2;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic [2:0]                func3;
    logic [6:0]                func7;
    ctrl_t                     ctrl;
  } bundle_t;

  logic [6:0] opcode;
  ctrl_t      ctrl_dec;
  bundle_t    dec;
  bundle_t    held;
  logic       legal;
  logic       use_rs1;
  logic       use_rs2;
  logic       hazard;
  logic       accept;
  logic       transfer;

  assign opcode = in_instr[6:0];

  // Opcode decode. Any opcode outside the table (which includes every word
  // whose low two bits are not 11) falls to the default and is flagged illegal.
  always_comb begin
    ctrl_dec = '0;
    legal    = 1'b1;
    use_rs1  = 1'b0;
    use_rs2  = 1'b0;
    case (opcode)
      OPC_OP: begin
        ctrl_dec.alu_op    = 2'b10;
        ctrl_dec.reg_write = 1'b1;
        use_rs1            = 1'b1;
        use_rs2            = 1'b1;
        if (in_instr[31:25] == 7'b0000001) begin
          if (ENABLE_M != 0) ctrl_dec.mul = 1'b1;
          else               legal        = 1'b0;
        end
      end
      OPC_OP_IMM: begin
        ctrl_dec.op2_src   = 1'b1;
        ctrl_dec.alu_op    = 2'b10;
        ctrl_dec.reg_write = 1'b1;
        use_rs1            = 1'b1;
      end
      OPC_LOAD: begin
        ctrl_dec.op2_src   = 1'b1;
        ctrl_dec.wb_src    = 2'b01;
        ctrl_dec.reg_write = 1'b1;
        ctrl_dec.mem_read  = 1'b1;
        use_rs1            = 1'b1;
      end
      OPC_STORE: begin
        ctrl_dec.op2_src   = 1'b1;
        ctrl_dec.imm_src   = 3'b001;
        ctrl_dec.mem_write = 1'b1;
        use_rs1            = 1'b1;
        use_rs2            = 1'b1;
      end
      OPC_BRANCH: begin
        ctrl_dec.alu_op    = 2'b01;
        ctrl_dec.imm_src   = 3'b010;
        ctrl_dec.branch    = 1'b1;
        use_rs1            = 1'b1;
        use_rs2            = 1'b1;
      end
      OPC_JAL: begin
        ctrl_dec.op1_src   = 1'b1;
        ctrl_dec.op2_src   = 1'b1;
        ctrl_dec.wb_src    = 2'b10;
        ctrl_dec.imm_src   = 3'b100;
        ctrl_dec.reg_write = 1'b1;
        ctrl_dec.jump      = 1'b1;
      end
      OPC_JALR: begin
        ctrl_dec.op2_src   = 1'b1;
        ctrl_dec.wb_src    = 2'b10;
        ctrl_dec.reg_write = 1'b1;
        ctrl_dec.jump      = 1'b1;
        use_rs1            = 1'b1;
      end
      OPC_LUI: begin
        ctrl_dec.op2_src   = 1'b1;
        ctrl_dec.alu_op    = 2'b11;
        ctrl_dec.imm_src   = 3'b011;
        ctrl_dec.reg_write = 1'b1;
      end
      OPC_AUIPC: begin
        ctrl_dec.op1_src   = 1'b1;
        ctrl_dec.op2_src   = 1'b1;
        ctrl_dec.imm_src   = 3'b011;
        ctrl_dec.reg_write = 1'b1;
      end
      default: legal = 1'b0;
    endcase
    // Illegal words still travel downstream for the trap logic, but with
    // every side-effecting control cleared.
    if (!legal) begin
      ctrl_dec         = '0;
      ctrl_dec.illegal = 1'b1;
    end
  end

  always_comb begin
    dec       = '0;
    dec.pc    = in_pc;
    dec.rs1   = REG_ADDR_WIDTH'(in_instr[19:15]);
    dec.rs2   = REG_ADDR_WIDTH'(in_instr[24:20]);
    dec.rd    = REG_ADDR_WIDTH'(in_instr[11:7]);
    dec.func3 = in_instr[14:12];
    dec.func7 = in_instr[31:25];
    dec.ctrl  = ctrl_dec;
  end

  // Load-use: the held load's data is not available to an instruction that
  // would sit directly behind it, so hold that instruction back one slot.
  assign hazard = out_valid && held.ctrl.mem_read && (held.rd != '0) &&
                  ((use_rs1 && (dec.rs1 == held.rd)) || (use_rs2 && (dec.rs2 == held.rd)));

  assign in_ready = !rst && (!out_valid || out_ready) && !hazard && !flush;
  assign accept   = in_valid && in_ready;
  assign transfer = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      held      <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      held      <= dec;
      out_valid <= 1'b1;
    end else if (transfer) begin
      out_valid <= 1'b0;
    end
  end

  assign out_pc        = held.pc;
  assign out_rs1       = held.rs1;
  assign out_rs2       = held.rs2;
  assign out_rd        = held.rd;
  assign out_func3     = held.func3;
  assign out_func7     = held.func7;
  assign out_alu_op    = held.ctrl.alu_op;
  assign out_imm_src   = held.ctrl.imm_src;
  assign out_op1_src   = held.ctrl.op1_src;
  assign out_op2_src   = held.ctrl.op2_src;
  assign out_wb_src    = held.ctrl.wb_src;
  assign out_reg_write = held.ctrl.reg_write;
  assign out_mem_write = held.ctrl.mem_write;
  assign out_mem_read  = held.ctrl.mem_read;
  assign out_branch    = held.ctrl.branch;
  assign out_jump      = held.ctrl.jump;
  assign out_mul       = held.ctrl.mul;
  assign out_illegal   = held.ctrl.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: scoreboard bench for decode_stage, ENABLE_M=0 and ENABLE_M=1 side by side.
// Stimulus is applied 1 time unit after the rising edge; handshakes are judged on the falling edge.
// Expected bundles are queued on accept and popped by a monitor when the DUT transfers.
module tb_decode_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_instr, in_pc;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [1:0]  alu;
    logic [2:0]  imm;
    logic        op1, op2;
    logic [1:0]  wb;
    logic        rw, mw, mr, br, jp, mul, ill;
  } bun_t;

  typedef struct packed { bun_t b0; bun_t b1; } exp_t;

  // One row per legal opcode: sources {op1,op2}, wb, alu, imm,
  // flags {reg_write,mem_write,mem_read,branch,jump}, uses {rs1,rs2}.
  typedef struct packed {
    logic [6:0] opc;
    logic [1:0] src;
    logic [1:0] wb;
    logic [1:0] alu;
    logic [2:0] imm;
    logic [4:0] flg;
    logic [1:0] use_rs;
  } row_t;

  row_t tbl [9];
  initial begin
    tbl[0] = {7'b0110011, 2'b00, 2'b00, 2'b10, 3'b000, 5'b10000, 2'b11};
    tbl[1] = {7'b0010011, 2'b01, 2'b00, 2'b10, 3'b000, 5'b10000, 2'b10};
    tbl[2] = {7'b0000011, 2'b01, 2'b01, 2'b00, 3'b000, 5'b10100, 2'b10};
    tbl[3] = {7'b0100011, 2'b01, 2'b00, 2'b00, 3'b001, 5'b01000, 2'b11};
    tbl[4] = {7'b1100011, 2'b00, 2'b00, 2'b01, 3'b010, 5'b00010, 2'b11};
    tbl[5] = {7'b1101111, 2'b11, 2'b10, 2'b00, 3'b100, 5'b10001, 2'b00};
    tbl[6] = {7'b1100111, 2'b01, 2'b10, 2'b00, 3'b000, 5'b10001, 2'b10};
    tbl[7] = {7'b0110111, 2'b01, 2'b00, 2'b11, 3'b011, 5'b10000, 2'b00};
    tbl[8] = {7'b0010111, 2'b11, 2'b00, 2'b00, 3'b011, 5'b10000, 2'b00};
  end

  // DUT with M disabled
  logic        in_ready, out_valid;
  logic [31:0] out_pc;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic [2:0]  out_func3, out_imm_src;
  logic [6:0]  out_func7;
  logic [1:0]  out_alu_op, out_wb_src;
  logic        out_op1_src, out_op2_src, out_reg_write, out_mem_write, out_mem_read;
  logic        out_branch, out_jump, out_mul, out_illegal;

  // DUT with M enabled
  logic        m_in_ready, m_out_valid;
  logic [31:0] m_out_pc;
  logic [4:0]  m_out_rs1, m_out_rs2, m_out_rd;
  logic [2:0]  m_out_func3, m_out_imm_src;
  logic [6:0]  m_out_func7;
  logic [1:0]  m_out_alu_op, m_out_wb_src;
  logic        m_out_op1_src, m_out_op2_src, m_out_reg_write, m_out_mem_write, m_out_mem_read;
  logic        m_out_branch, m_out_jump, m_out_mul, m_out_illegal;

  decode_stage #(.PC_WIDTH(32), .ENABLE_M(0), .REG_ADDR_WIDTH(5)) u_dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_func3(out_func3), .out_func7(out_func7), .out_alu_op(out_alu_op),
    .out_imm_src(out_imm_src), .out_op1_src(out_op1_src), .out_op2_src(out_op2_src),
    .out_wb_src(out_wb_src), .out_reg_write(out_reg_write), .out_mem_write(out_mem_write),
    .out_mem_read(out_mem_read), .out_branch(out_branch), .out_jump(out_jump),
    .out_mul(out_mul), .out_illegal(out_illegal)
  );

  decode_stage #(.PC_WIDTH(32), .ENABLE_M(1), .REG_ADDR_WIDTH(5)) u_dut_m (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(m_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(m_out_valid), .out_ready(out_ready),
    .out_pc(m_out_pc), .out_rs1(m_out_rs1), .out_rs2(m_out_rs2), .out_rd(m_out_rd),
    .out_func3(m_out_func3), .out_func7(m_out_func7), .out_alu_op(m_out_alu_op),
    .out_imm_src(m_out_imm_src), .out_op1_src(m_out_op1_src), .out_op2_src(m_out_op2_src),
    .out_wb_src(m_out_wb_src), .out_reg_write(m_out_reg_write), .out_mem_write(m_out_mem_write),
    .out_mem_read(m_out_mem_read), .out_branch(m_out_branch), .out_jump(m_out_jump),
    .out_mul(m_out_mul), .out_illegal(m_out_illegal)
  );

  bun_t dut_b, dutm_b;
  assign dut_b  = {out_pc, out_rs1, out_rs2, out_rd, out_func3, out_func7, out_alu_op,
                   out_imm_src, out_op1_src, out_op2_src, out_wb_src, out_reg_write,
                   out_mem_write, out_mem_read, out_branch, out_jump, out_mul, out_illegal};
  assign dutm_b = {m_out_pc, m_out_rs1, m_out_rs2, m_out_rd, m_out_func3, m_out_func7,
                   m_out_alu_op, m_out_imm_src, m_out_op1_src, m_out_op2_src, m_out_wb_src,
                   m_out_reg_write, m_out_mem_write, m_out_mem_read, m_out_branch,
                   m_out_jump, m_out_mul, m_out_illegal};

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit lookup(input logic [6:0] opc, output row_t r);
    r = '0;
    for (int i = 0; i < 9; i++)
      if (tbl[i].opc == opc) begin
        r = tbl[i];
        return 1'b1;
      end
    return 1'b0;
  endfunction

  function automatic bun_t model_decode(input logic [31:0] ins, input logic [31:0] pc, input bit em);
    bun_t b;
    row_t r;
    bit   ok;
    b = '0;
    b.pc = pc;
    b.rs1 = ins[19:15];
    b.rs2 = ins[24:20];
    b.rd = ins[11:7];
    b.f3 = ins[14:12];
    b.f7 = ins[31:25];
    ok = lookup(ins[6:0], r);
    if (ok && ins[6:0] == 7'b0110011 && ins[31:25] == 7'b0000001) begin
      if (em) b.mul = 1'b1;
      else    ok = 1'b0;
    end
    if (!ok) begin
      b.ill = 1'b1;
    end else begin
      {b.op1, b.op2} = r.src;
      b.wb = r.wb;
      b.alu = r.alu;
      b.imm = r.imm;
      {b.rw, b.mw, b.mr, b.br, b.jp} = r.flg;
    end
    return b;
  endfunction

  function automatic bit model_hazard(input bun_t h, input logic [31:0] ins);
    row_t r;
    bit   ok;
    ok = lookup(ins[6:0], r);
    return ok && h.mr && (h.rd != 5'd0) &&
           ((r.use_rs[1] && ins[19:15] == h.rd) || (r.use_rs[0] && ins[24:20] == h.rd));
  endfunction

  exp_t exp_q[$];
  bit   acc;
  bit   m_held, m_haz, m_rdy;

  // Handshake checker: predicts in_ready/out_valid and queues accepted instructions.
  always @(negedge clk) begin
    if (rst) begin
      acc = 1'b0;
      chk("in_ready_in_reset", in_ready, 0);
      chk("out_valid_in_reset", out_valid, 0);
    end else begin
      m_held = exp_q.size() != 0;
      m_haz = 1'b0;
      if (m_held) m_haz = model_hazard(exp_q[0].b0, in_instr);
      m_rdy = (!m_held || out_ready) && !m_haz && !flush;
      chk("in_ready", in_ready, m_rdy);
      chk("in_ready_m", m_in_ready, m_rdy);
      chk("out_valid", out_valid, m_held);
      chk("out_valid_m", m_out_valid, m_held);
      acc = in_valid && m_rdy;
      if (acc) exp_q.push_back({model_decode(in_instr, in_pc, 1'b0), model_decode(in_instr, in_pc, 1'b1)});
    end
  end

  // Monitor: pops and compares whenever the DUT hands a bundle to execute.
  exp_t e;
  always @(negedge clk) begin
    #1;
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_transfer: got bundle %0h expected none", dut_b);
        end else begin
          e = exp_q.pop_front();
          chk("bundle", dut_b, e.b0);
          chk("bundle_m", dutm_b, e.b1);
        end
      end else if (flush && exp_q.size() != 0) begin
        void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                     input bit ordy, input bit fl, output bit a);
    in_valid = v;
    in_instr = ins;
    in_pc = pc;
    out_ready = ordy;
    flush = fl;
    @(negedge clk);
    #2;
    a = acc;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] ins, input logic [31:0] pc, input bit ordy);
    bit a;
    a = 1'b0;
    for (int n = 0; n < 20 && !a; n++) cyc(1'b1, ins, pc, ordy, 1'b0, a);
    chk("accepted_within_budget", a, 1);
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, a);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    int k;
    w = $urandom;
    k = $urandom_range(0, 10);
    if (k < 9) w[6:0] = tbl[k].opc;
    w[11:7] = 5'($urandom_range(0, 3));
    w[19:15] = 5'($urandom_range(0, 3));
    w[24:20] = 5'($urandom_range(0, 3));
    k = $urandom_range(0, 3);
    if (k == 0) w[31:25] = 7'b0000001;
    else if (k == 1) w[31:25] = 7'b0000000;
    return w;
  endfunction

  initial begin
    bit a;
    rst = 1'b1;
    flush = 1'b0;
    in_valid = 1'b0;
    in_instr = 32'h0;
    in_pc = 32'h0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_bundle", dut_b, 0);
    chk("reset_bundle_m", dutm_b, 0);
    rst = 1'b0;

    // back-to-back add / addi
    send(32'h003100B3, 32'h100, 1'b1);
    send(32'h00508213, 32'h104, 1'b1);
    idle(2);

    // lw x5,0(x6) then add x7,x5,x8: one bubble
    send(32'h00032283, 32'h200, 1'b1);
    send(32'h008283B3, 32'h204, 1'b1);
    idle(2);

    // backpressure for three cycles, then release
    send(32'h00508213, 32'h300, 1'b0);
    repeat (3) cyc(1'b1, 32'h123452B7, 32'h304, 1'b0, 1'b0, a);
    send(32'h123452B7, 32'h304, 1'b1);
    idle(2);

    // flush while holding a JAL with an instruction waiting
    send(32'h008000EF, 32'h400, 1'b0);
    cyc(1'b1, 32'h00508213, 32'h404, 1'b0, 1'b1, a);
    idle(2);

    // mul, unknown opcode, low bits not 11
    send(32'h023100B3, 32'h500, 1'b1);
    send(32'h0000007F, 32'h504, 1'b1);
    send(32'h00000010, 32'h508, 1'b1);
    idle(2);

    // reset mid-stream while holding a bundle
    send(32'h00508213, 32'h600, 1'b0);
    rst = 1'b1;
    #1;
    chk("async_rst_bundle", dut_b, 0);
    chk("async_rst_bundle_m", dutm_b, 0);
    chk("async_rst_out_valid", out_valid, 0);
    chk("async_rst_in_ready", in_ready, 0);
    exp_q.delete();
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(1);

    // random traffic
    for (int i = 0; i < 800; i++) begin
      cyc($urandom_range(0, 3) != 0, rand_instr(), $urandom & 32'hFFFF_FFFC,
          $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, a);
    end
    idle(4);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
Registered RV32I instruction-decode stage. It sits between the fetch stage and the execute stage. It decodes a 32-bit instruction into control signals and holds the result in a single output register with valid/ready handshakes on both sides. It adds the following:
- load-use hazard bubbling
- synchronous flush
- illegal-instruction flagging
- optional M-extension decode

Parameters:
PC_WIDTH, 32, width of the program counter carried alongside the instruction
ENABLE_M, 0, 1 = accept M-extension opcodes (OP with func7=0000001); 0 = flag them illegal
REG_ADDR_WIDTH, 5, register index width

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
flush  input  1  discard held and incoming instruction (branch/jump redirect)
in_valid  input  1  fetch presents an instruction
in_ready  output  1  stage accepts the instruction this cycle
in_instr  input  32  instruction word
in_pc  input  PC_WIDTH  instruction PC
out_valid  output  1  decoded bundle valid
out_ready  input  1  execute accepts the bundle
out_pc  output  PC_WIDTH  registered PC
out_rs1, out_rs2, out_rd  output  REG_ADDR_WIDTH each  register indices (instr[19:15], [24:20], [11:7])
out_func3  output  3  instr[14:12]
out_func7  output  7  instr[31:25]
out_alu_op  output  2  00 add, 01 sub/compare, 10 func3/func7-decoded, 11 pass operand B
out_imm_src  output  3  000 I, 001 S, 010 B, 011 U, 100 J
out_op1_src  output  1  0 rs1, 1 PC
out_op2_src  output  1  0 rs2, 1 immediate
out_wb_src  output  2  00 ALU, 01 memory, 10 PC+4
out_reg_write, out_mem_write, out_mem_read, out_branch, out_jump, out_mul, out_illegal  output  1 each  control flags

Behaviour:
- Reset (asynchronous, active-high): every out_* register goes to 0, including out_valid. in_ready = 0 while rst is high.

Decode table (op1/op2/wb/alu_op/imm/flags):
- OP 0110011: 0/0/00/10/000, reg_write. If func7=0000001: out_mul=1 when ENABLE_M; otherwise illegal.
- OP-IMM 0010011: 0/1/00/10/000, reg_write.
- LOAD 0000011: 0/1/01/00/000, reg_write, mem_read.
- STORE 0100011: 0/1/00/00/001, mem_write.
- BRANCH 1100011: 0/0/00/01/010, branch.
- JAL 1101111: 1/1/10/00/100, reg_write, jump.
- JALR 1100111: 0/1/10/00/000, reg_write, jump.
- LUI 0110111: 0/1/00/11/011, reg_write.
- AUIPC 0010111: 1/1/00/00/011, reg_write.
- Any other opcode, or instr[1:0] != 11: out_illegal=1. All of reg_write, mem_write, mem_read, branch, jump = 0. The instruction is still passed downstream with out_valid=1 so the trap logic can see it.

Handshake:
- Accept when in_valid && in_ready.
- Transfer when out_valid && out_ready.
- in_ready = (!out_valid || out_ready) && !hazard && !flush.
- On accept: the output register loads the decoded bundle and out_valid=1 on the next edge. Latency is 1 cycle; sustained throughput is 1/cycle.
- On transfer without accept: out_valid=0 next edge.
- When not transferring, the output register and all out_* hold stable.

Hazard (combinational):
- hazard = out_valid && out_mem_read && out_rd != 0 && (rs1 uses && in rs1 == out_rd || rs2 uses && in rs2 == out_rd).
- rs1 is used by OP, OP-IMM, LOAD, STORE, BRANCH, JALR.
- rs2 is used by OP, STORE, BRANCH.
- Effect: exactly one bubble is inserted after the load transfers.

Flush:
- Takes priority over everything.
- Next edge: out_valid=0. The incoming instruction is dropped (in_ready=0 that cycle).
- Simultaneous flush and out_ready: the held bundle counts as transferred only if execute sampled it; the stage clears regardless.

Test Plan:
- Reset mid-stream: assert rst with out_valid=1 -> all outputs 0 immediately (asynchronous), in_ready=0. Release -> in_ready=1 next cycle.
- Back-to-back add x1,x2,x3 (0x003100B3) then addi x4,x1,5 with out_ready=1 -> out_valid on consecutive cycles. ADD: alu_op=10, op2_src=0. ADDI: op2_src=1, imm_src=000. No stalls.
- lw x5,0(x6) followed by add x7,x5,x8 -> in_ready=0 for one cycle after lw is accepted. Exactly one out_valid=0 cycle between lw and add.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, out_* stable. Release -> the held bundle transfers, then the next instruction is accepted.
- flush while holding JAL and in_valid=1 -> out_valid=0 next cycle; the incoming instruction never appears at the output.
- mul x1,x2,x3 (0x023100B3): ENABLE_M=0 -> out_illegal=1, reg_write=0. ENABLE_M=1 -> out_mul=1, illegal=0. Opcode 0x7F -> out_illegal=1.
